instruction_fetch_unit: RTL

Initiator side of the instruction-memory read interface. Holds the PC, drives a byte address to the asynchronous instruction memory and captures the 32-bit little-endian word it returns. Fetched {pc, instr} pairs are buffered and handed to decode over a valid/ready handshake. Also handles taken-branch/jump redirects from execute, and latches a sticky fault on misaligned or out-of-range fetches.

---
 rtl/riscv_fetch_pkg.sv | 18 +
 rtl/fetch_skid_buffer.sv | 56 +++++
 rtl/instruction_fetch_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its output buffer.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO of fetched {pc, instr} pairs with synchronous flush.
module fetch_skid_buffer
  import riscv_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_push_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);

  fetch_entry_t r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  // Local guards keep the FIFO safe even if a caller violates full/empty.
  assign w_push = i_push && (r_count != 2'd2);
  assign w_pop  = i_pop  && (r_count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, boot/run/fault FSM, redirect handling, range/alignment faults.
module instruction_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int unsigned MEM_BYTES = 256,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        fault,
  output logic [63:0] fault_pc
);

  localparam logic [1:0]  FULL_COUNT    = 2'(BUF_DEPTH);
  // pc+3 < MEM_BYTES rewritten as pc <= MEM_BYTES-4 so it cannot overflow.
  localparam logic [63:0] LAST_FETCH_PC = 64'(MEM_BYTES) - 64'(INSTR_BYTES);

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic [63:0]  r_pc;
  logic         r_fault;
  logic [63:0]  r_fault_pc;

  logic         w_full;
  logic         w_in_range;
  logic         w_push;
  logic         w_pop;
  logic         w_flush;
  logic         w_pc_load;
  logic         w_pc_inc;
  logic         w_fault_set;
  logic [63:0]  w_fault_addr;
  logic [1:0]   w_count;
  fetch_entry_t w_head;
  fetch_entry_t w_push_entry;

  assign w_full     = (w_count == FULL_COUNT);
  assign w_in_range = (r_pc <= LAST_FETCH_PC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    w_pc_load    = 1'b0;
    w_pc_inc     = 1'b0;
    w_fault_set  = 1'b0;
    w_fault_addr = '0;
    if (r_state == ST_BOOT) begin
      w_next_state = ST_RUN;
    end
    if ((r_state != ST_FAULT) && redirect_valid) begin
      w_flush = 1'b1;
      if (redirect_pc[1:0] != 2'b00) begin
        w_next_state = ST_FAULT;
        w_fault_set  = 1'b1;
        w_fault_addr = redirect_pc;
      end else begin
        w_pc_load = 1'b1;
      end
    end else if ((r_state == ST_RUN) && !w_full) begin
      if (w_in_range) begin
        w_push   = 1'b1;
        w_pc_inc = 1'b1;
      end else begin
        w_next_state = ST_FAULT;
        w_fault_set  = 1'b1;
        w_fault_addr = r_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_pc_load) begin
      r_pc <= redirect_pc;
    end else if (w_pc_inc) begin
      r_pc <= r_pc + 64'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else if (w_fault_set) begin
      r_fault    <= 1'b1;
      r_fault_pc <= w_fault_addr;
    end
  end

  assign w_push_entry = '{pc: r_pc, instr: imem_rdata};
  assign w_pop        = out_valid && out_ready;

  fetch_skid_buffer u_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (w_flush),
    .o_head       (w_head),
    .o_count      (w_count)
  );

  assign imem_addr = r_pc;
  assign out_valid = (w_count != 2'd0);
  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;
  assign fault     = r_fault;
  assign fault_pc  = r_fault_pc;

endmodule
